qracc_sram_seq: RTL and testbench

//  Multi-bank digital sequencer between the sram_itf request handshake and the analog SRAM macro pins.

---
 rtl/qracc_pkg.sv | 29 ++
 rtl/qracc_sram_phase_timer.sv | 26 ++
 rtl/qracc_sram_seq.sv | 174 +++++++++++++++++
 tb/tb_qracc_sram_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// Shared types for the QRACC SRAM sequencer: FSM state encoding, request bundle and helpers.
package qracc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PCH,
        S_WL,
        S_SENSE,
        S_DONE
    } sram_seq_state_t;

    localparam int SRAM_ADDR_W = 8;
    localparam int SRAM_DATA_W = 32;

    // Request bundle as seen on the sram_itf side for the default 2x128x32 geometry.
    typedef struct packed {
        logic                   wr;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wr_data;
        logic [SRAM_DATA_W-1:0] wr_mask;
    } to_sram_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/qracc_sram_phase_timer.sv
// Loadable down-counter that times one sequencer phase; zero marks the phase's last cycle.
module qracc_sram_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/qracc_sram_seq.sv
// Multi-bank SRAM macro sequencer: each request runs precharge -> wordline -> (sense) phases.
// Column write mask is enabled by defining QRACC_SRAM_WMASK_EN; otherwise writes drive all columns.
module qracc_sram_seq
    import qracc_pkg::*;
#(
    parameter int numRows    = 128,
    parameter int numCols    = 32,
    parameter int numBanks   = 2,
    parameter int pchCycles  = 1,
    parameter int wlCycles   = 1,
    parameter int saenCycles = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rq_wr_i,
    input  logic                                  rq_valid_i,
    output logic                                  rq_ready_o,
    input  logic [$clog2(numRows*numBanks)-1:0]   addr_i,
    input  logic [numCols-1:0]                    wr_data_i,
    input  logic [numCols-1:0]                    wr_mask_i,
    output logic                                  rd_valid_o,
    output logic [numCols-1:0]                    rd_data_o,
    output logic [numBanks*numRows-1:0]           WL,
    output logic [numBanks-1:0]                   PCH,
    output logic [numBanks-1:0]                   WRITE,
    output logic [numCols-1:0]                    WR_DATA,
    output logic [numCols-1:0]                    CSEL,
    output logic [numBanks-1:0]                   SAEN,
    input  logic [numBanks*numCols-1:0]           SA_OUT
);

    localparam int ADDR_W = $clog2(numRows*numBanks);
    localparam int BANK_W = (numBanks > 1) ? $clog2(numBanks) : 1;
    localparam int NWL    = numBanks*numRows;
    localparam int TMR_W  = $clog2(max3(pchCycles, wlCycles, saenCycles)) + 1;

    sram_seq_state_t     state;
    logic                op_wr;
    logic [ADDR_W-1:0]   addr_q;
    logic [numCols-1:0]  data_q;
    logic [numCols-1:0]  wmask_q;
    logic [numCols-1:0]  wmask_in;
    logic [BANK_W-1:0]   bank_in;
    logic [BANK_W-1:0]   bank_q;
    logic [numBanks-1:0] bank_oh_in;
    logic [numBanks-1:0] bank_oh_q;
    logic                accept;
    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_zero;

    if (numBanks > 1) begin : g_bank
        assign bank_in = addr_i[ADDR_W-1 -: BANK_W];
        assign bank_q  = addr_q[ADDR_W-1 -: BANK_W];
    end else begin : g_no_bank
        assign bank_in = '0;
        assign bank_q  = '0;
    end

    assign bank_oh_in = numBanks'(1) << bank_in;
    assign bank_oh_q  = numBanks'(1) << bank_q;
    assign accept     = rq_valid_i && rq_ready_o;

`ifdef QRACC_SRAM_WMASK_EN
    assign wmask_in = wr_mask_i;
`else
    assign wmask_in = '1;
    logic unused_mask;
    assign unused_mask = ^wr_mask_i;
`endif

    // Reload the timer on the edge that enters the next phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE:  if (accept)   begin tmr_load = 1'b1; tmr_val = TMR_W'(pchCycles - 1);  end
            S_PCH:   if (tmr_zero) begin tmr_load = 1'b1; tmr_val = TMR_W'(wlCycles - 1);   end
            S_WL:    if (tmr_zero) begin tmr_load = 1'b1; tmr_val = TMR_W'(saenCycles - 1); end
            default: ;
        endcase
    end

    qracc_sram_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rq_ready_o <= 1'b1;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            WL         <= '0;
            PCH        <= '0;
            WRITE      <= '0;
            WR_DATA    <= '0;
            CSEL       <= '0;
            SAEN       <= '0;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wmask_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_wr      <= rq_wr_i;
                        addr_q     <= addr_i;
                        data_q     <= wr_data_i;
                        wmask_q    <= wmask_in;
                        rq_ready_o <= 1'b0;
                        PCH        <= bank_oh_in;
                        state      <= S_PCH;
                    end
                end
                S_PCH: begin
                    // PCH drops on the same edge WL rises, so they never overlap.
                    if (tmr_zero) begin
                        PCH   <= '0;
                        WL    <= NWL'(1) << addr_q;
                        state <= S_WL;
                        if (op_wr) begin
                            WRITE   <= bank_oh_q;
                            WR_DATA <= data_q & wmask_q;
                            CSEL    <= wmask_q;
                        end else begin
                            CSEL <= '1;
                        end
                    end
                end
                S_WL: begin
                    if (tmr_zero) begin
                        WRITE   <= '0;
                        WR_DATA <= '0;
                        if (op_wr) begin
                            WL         <= '0;
                            CSEL       <= '0;
                            rq_ready_o <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            SAEN  <= bank_oh_q;
                            state <= S_SENSE;
                        end
                    end
                end
                S_SENSE: begin
                    if (tmr_zero) begin
                        SAEN       <= '0;
                        WL         <= '0;
                        CSEL       <= '0;
                        rd_data_o  <= SA_OUT[bank_q*numCols +: numCols];
                        rd_valid_o <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    rd_valid_o <= 1'b0;
                    rq_ready_o <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    rq_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_sram_seq.sv
// Bench for qracc_sram_seq: two DUTs (1/1/1 and 3/2/2 phase lengths), a behavioural SRAM macro,
// a cycle-timeline pin model and a read-data scoreboard.
module tb_qracc_sram_seq;

    localparam int PW = 328;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rq_wr     [2];
    logic        rq_valid  [2];
    logic        rq_ready  [2];
    logic [7:0]  addr      [2];
    logic [31:0] wr_data   [2];
    logic [31:0] wr_mask   [2];
    logic        rd_valid  [2];
    logic [31:0] rd_data   [2];
    logic [255:0] wl       [2];
    logic [1:0]  pch       [2];
    logic [1:0]  write     [2];
    logic [1:0]  saen      [2];
    logic [31:0] wdata_pin [2];
    logic [31:0] csel      [2];
    logic [63:0] sa_out    [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        qracc_sram_seq #(
            .numRows(128), .numCols(32), .numBanks(2),
            .pchCycles(g == 0 ? 1 : 3), .wlCycles(g == 0 ? 1 : 2), .saenCycles(g == 0 ? 1 : 2)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .rq_wr_i    (rq_wr[g]),
            .rq_valid_i (rq_valid[g]),
            .rq_ready_o (rq_ready[g]),
            .addr_i     (addr[g]),
            .wr_data_i  (wr_data[g]),
            .wr_mask_i  (wr_mask[g]),
            .rd_valid_o (rd_valid[g]),
            .rd_data_o  (rd_data[g]),
            .WL         (wl[g]),
            .PCH        (pch[g]),
            .WRITE      (write[g]),
            .WR_DATA    (wdata_pin[g]),
            .CSEL       (csel[g]),
            .SAEN       (saen[g]),
            .SA_OUT     (sa_out[g])
        );
    end

    int checks = 0;
    int failures = 0;
    bit started = 0;

    int pch_n  [2] = '{1, 3};
    int wl_n   [2] = '{1, 2};
    int saen_n [2] = '{1, 2};

    // Reference model: current operation and cycles elapsed since its accept.
    bit          act    [2];
    int          k      [2];
    bit          m_wr   [2];
    logic [7:0]  m_addr [2];
    logic [31:0] m_data [2];
    logic [31:0] m_wm   [2];
    int          acc_cnt[2];
    logic [31:0] ref_mem [2][256];
    logic [31:0] arr     [2][256];
    logic [31:0] rdq     [2][$];

    task automatic chk(input bit ok, input string what);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s", what);
        end
    endtask

    function automatic int op_len(input int i);
        return m_wr[i] ? pch_n[i] + wl_n[i] : pch_n[i] + wl_n[i] + saen_n[i] + 1;
    endfunction

    function automatic logic [PW-1:0] exp_pins(input int i);
        logic         ready_e, rv_e;
        logic [1:0]   pch_e, wr_e, saen_e, boh;
        logic [31:0]  csel_e, wd_e;
        logic [255:0] wl_e;
        int p, w, s;
        p = pch_n[i]; w = wl_n[i]; s = saen_n[i];
        ready_e = 1'b1; rv_e = 1'b0;
        pch_e = '0; wr_e = '0; saen_e = '0; csel_e = '0; wd_e = '0; wl_e = '0;
        if (act[i]) begin
            boh = 2'b01 << m_addr[i][7];
            if (k[i] <= op_len(i)) ready_e = 1'b0;
            if (k[i] >= 1 && k[i] <= p) pch_e = boh;
            if (k[i] > p && k[i] <= p + w) begin
                wl_e = 256'd1 << m_addr[i];
                if (m_wr[i]) begin
                    wr_e   = boh;
                    csel_e = m_wm[i];
                    wd_e   = m_data[i] & m_wm[i];
                end else begin
                    csel_e = '1;
                end
            end
            if (!m_wr[i] && k[i] > p + w && k[i] <= p + w + s) begin
                wl_e   = 256'd1 << m_addr[i];
                saen_e = boh;
                csel_e = '1;
            end
            if (!m_wr[i] && k[i] == p + w + s + 1) rv_e = 1'b1;
        end
        return {ready_e, rv_e, pch_e, wr_e, saen_e, csel_e, wd_e, wl_e};
    endfunction

    // Model update on each active edge: accept, phase progress, reset.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit idle_now;
            if (rst) begin
                act[i] = 0;
                k[i]   = 0;
                rdq[i].delete();
            end else begin
                idle_now = !act[i] || (k[i] > op_len(i));
                if (rq_valid[i] && idle_now) begin
                    act[i]    = 1;
                    k[i]      = 1;
                    m_wr[i]   = rq_wr[i];
                    m_addr[i] = addr[i];
                    m_data[i] = wr_data[i];
`ifdef QRACC_SRAM_WMASK_EN
                    m_wm[i]   = wr_mask[i];
`else
                    m_wm[i]   = '1;
`endif
                    if (rq_wr[i])
                        ref_mem[i][addr[i]] = (ref_mem[i][addr[i]] & ~m_wm[i]) | (wr_data[i] & m_wm[i]);
                    else
                        rdq[i].push_back(ref_mem[i][addr[i]]);
                    acc_cnt[i]++;
                end else if (act[i] && k[i] <= op_len(i)) begin
                    k[i]++;
                end
            end
        end
    end

    // Pin timeline check.
    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                logic [PW-1:0] got, exp;
                got = {rq_ready[i], rd_valid[i], pch[i], write[i], saen[i], csel[i], wdata_pin[i], wl[i]};
                exp = exp_pins(i);
                chk(got === exp, $sformatf("pins%0d k=%0d got=%h exp=%h", i, k[i], got, exp));
            end
        end
    end

    // Read-data scoreboard.
    initial forever begin
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                if (rd_valid[i] === 1'b1) begin
                    logic [31:0] exp_d;
                    chk(rdq[i].size() != 0, $sformatf("rd_unexpected%0d got=%h", i, rd_data[i]));
                    if (rdq[i].size() != 0) begin
                        exp_d = rdq[i].pop_front();
                        chk(rd_data[i] === exp_d, $sformatf("rd_data%0d got=%h exp=%h", i, rd_data[i], exp_d));
                    end
                end
            end
        end
    end

    // Behavioural SRAM macro: writes on WRITE+WL, sense-amp outputs valid only under SAEN.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 2; b++) begin
                int row;
                row = -1;
                for (int r = 0; r < 128; r++)
                    if (wl[i][b*128 + r] === 1'b1) row = b*128 + r;
                if (row >= 0 && write[i][b] === 1'b1)
                    arr[i][row] = (arr[i][row] & ~csel[i]) | (wdata_pin[i] & csel[i]);
                sa_out[i][b*32 +: 32] = (row >= 0 && saen[i][b] === 1'b1) ? arr[i][row]
                                                                          : (32'hBAD0_0000 | 32'(b));
            end
        end
    end

    task automatic send(input int i, input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] m);
        int n0, guard;
        n0 = acc_cnt[i];
        guard = 0;
        rq_wr[i] = wr; addr[i] = a; wr_data[i] = d; wr_mask[i] = m;
        rq_valid[i] = 1'b1;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (acc_cnt[i] == n0 && guard < 200);
        chk(acc_cnt[i] != n0, $sformatf("accept_timeout%0d got=%0d exp=%0d", i, acc_cnt[i], n0 + 1));
        rq_valid[i] = 1'b0;
        rq_wr[i] = 1'($urandom); addr[i] = 8'($urandom);
        wr_data[i] = $urandom; wr_mask[i] = $urandom;
    endtask

    task automatic wait_idle(input int i);
        int guard;
        guard = 0;
        while (act[i] && k[i] <= op_len(i) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic rand_run(input int i);
        logic [7:0] a;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a = ($urandom_range(0, 1) != 0) ? 8'($urandom) : (8'($urandom_range(0, 1)) << 7) | 8'($urandom_range(0, 7));
            send(i, 1'($urandom), a, $urandom, $urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rq_valid[i] = 1'b0; rq_wr[i] = 1'b0; addr[i] = '0;
            wr_data[i] = '0; wr_mask[i] = '0; sa_out[i] = '0;
            act[i] = 0; k[i] = 0; acc_cnt[i] = 0;
            for (int j = 0; j < 256; j++) begin
                ref_mem[i][j] = $urandom;
                arr[i][j] = ref_mem[i][j];
            end
        end
        @(posedge clk); #1;
        started = 1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        chk(rd_data[0] === 32'h0 && rd_data[1] === 32'h0,
            $sformatf("reset_rd_data got=%h/%h exp=0", rd_data[0], rd_data[1]));

        // Write then read 0x85 on both geometries; second request is held while busy.
        send(0, 1'b1, 8'h85, 32'hA5A5_5A5A, 32'hFFFF_FFFF);
        send(0, 1'b0, 8'h85, 32'h0, 32'h0);
        wait_idle(0);
        chk(rd_data[0] === 32'hA5A5_5A5A, $sformatf("t2_rd got=%h exp=a5a55a5a", rd_data[0]));
        send(1, 1'b1, 8'h85, 32'h1234_5678, 32'hFFFF_FFFF);
        send(1, 1'b0, 8'h85, 32'h0, 32'h0);
        send(1, 1'b0, 8'h03, 32'h0, 32'h0);
        wait_idle(1);

        // Partial column mask, then read back.
        send(0, 1'b1, 8'h10, 32'hCAFE_F00D, 32'h0000_FFFF);
        send(0, 1'b0, 8'h10, 32'h0, 32'h0);
        // Bank 0 top row: other bank must stay quiet.
        send(0, 1'b0, 8'h7F, 32'h0, 32'h0);
        send(0, 1'b1, 8'hFF, 32'h0F0F_0F0F, 32'hFFFF_0000);
        send(0, 1'b0, 8'hFF, 32'h0, 32'h0);
        wait_idle(0);

        // Reset for two cycles in the middle of a read.
        send(0, 1'b0, 8'h85, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        chk(rd_data[0] === 32'h0, $sformatf("midop_reset_rd got=%h exp=0", rd_data[0]));
        chk(rq_ready[0] === 1'b1, $sformatf("midop_reset_ready got=%b exp=1", rq_ready[0]));
        repeat (8) begin @(posedge clk); #1; end

        fork
            rand_run(0);
            rand_run(1);
        join
        wait_idle(0);
        wait_idle(1);
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 2; i++)
            chk(rdq[i].size() == 0, $sformatf("reads_pending%0d got=%0d exp=0", i, rdq[i].size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
